// File: rtl/ysyx_22050133_mem_arbiter_if.sv
// Signal bundle around the IFU/LSU-to-master memory arbiter; names carry the arbiter's own
// direction suffixes, so the master modport is the arbiter and the slave modport its surroundings.
interface ysyx_22050133_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  if_req_valid_i;
  logic                  if_req_ready_o;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [7:0]            if_len_i;
  logic [2:0]            if_size_i;
  logic [1:0]            if_burst_i;
  logic                  if_rdata_valid_o;
  logic                  if_rdata_ready_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  logic                  ls_req_valid_i;
  logic                  ls_req_ready_o;
  logic                  ls_we_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [7:0]            ls_len_i;
  logic [2:0]            ls_size_i;
  logic [1:0]            ls_burst_i;
  logic                  ls_wdata_valid_i;
  logic                  ls_wdata_ready_o;
  logic [DATA_WIDTH-1:0] ls_wdata_i;
  logic                  ls_rdata_valid_o;
  logic                  ls_rdata_ready_i;
  logic [DATA_WIDTH-1:0] ls_rdata_o;

  logic                  rw_addr_valid_o;
  logic                  rw_addr_ready_i;
  logic [ADDR_WIDTH-1:0] rw_addr_o;
  logic                  rw_we_o;
  logic [7:0]            rw_len_o;
  logic [2:0]            rw_size_o;
  logic [1:0]            rw_burst_o;
  logic                  rw_if_o;
  logic                  w_data_valid_o;
  logic                  w_data_ready_i;
  logic [DATA_WIDTH-1:0] w_data_o;
  logic                  r_data_valid_i;
  logic                  r_data_ready_o;
  logic [DATA_WIDTH-1:0] r_data_i;

  modport master (
    input  if_req_valid_i, if_addr_i, if_len_i, if_size_i, if_burst_i, if_rdata_ready_i,
    input  ls_req_valid_i, ls_we_i, ls_addr_i, ls_len_i, ls_size_i, ls_burst_i,
    input  ls_wdata_valid_i, ls_wdata_i, ls_rdata_ready_i,
    input  rw_addr_ready_i, w_data_ready_i, r_data_valid_i, r_data_i,
    output if_req_ready_o, if_rdata_valid_o, if_rdata_o,
    output ls_req_ready_o, ls_wdata_ready_o, ls_rdata_valid_o, ls_rdata_o,
    output rw_addr_valid_o, rw_addr_o, rw_we_o, rw_len_o, rw_size_o, rw_burst_o, rw_if_o,
    output w_data_valid_o, w_data_o, r_data_ready_o
  );

  modport slave (
    output if_req_valid_i, if_addr_i, if_len_i, if_size_i, if_burst_i, if_rdata_ready_i,
    output ls_req_valid_i, ls_we_i, ls_addr_i, ls_len_i, ls_size_i, ls_burst_i,
    output ls_wdata_valid_i, ls_wdata_i, ls_rdata_ready_i,
    output rw_addr_ready_i, w_data_ready_i, r_data_valid_i, r_data_i,
    input  if_req_ready_o, if_rdata_valid_o, if_rdata_o,
    input  ls_req_ready_o, ls_wdata_ready_o, ls_rdata_valid_o, ls_rdata_o,
    input  rw_addr_valid_o, rw_addr_o, rw_we_o, rw_len_o, rw_size_o, rw_burst_o, rw_if_o,
    input  w_data_valid_o, w_data_o, r_data_ready_o
  );
endinterface

// File: rtl/ysyx_22050133_mem_arbiter.sv
// Two-to-one IFU/LSU arbiter in front of the AXI master: one owner holds the master for the
// address handshake and all data beats; handshakes are combinational passthrough.
module ysyx_22050133_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_22050133_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_e     state_q;
  logic       owner_q;
  logic       last_grant_q;
  logic [7:0] len_q;
  logic [7:0] beat_cnt_q;

  logic       addr_hs_s;
  logic       data_hs_s;
  logic       grant_ls_s;

  assign addr_hs_s  = bus.rw_addr_valid_o & bus.rw_addr_ready_i;
  assign data_hs_s  = (bus.r_data_valid_i & bus.r_data_ready_o) |
                      (bus.w_data_valid_o & bus.w_data_ready_i);
  assign grant_ls_s = bus.ls_req_valid_i & (~bus.if_req_valid_i | (last_grant_q == OWNER_IFU));

  // Route the owner's signals; holding rst forces every output low during the reset cycle.
  always_comb begin
    bus.if_req_ready_o   = 1'b0;
    bus.if_rdata_valid_o = 1'b0;
    bus.if_rdata_o       = {DATA_WIDTH{1'b0}};
    bus.ls_req_ready_o   = 1'b0;
    bus.ls_wdata_ready_o = 1'b0;
    bus.ls_rdata_valid_o = 1'b0;
    bus.ls_rdata_o       = {DATA_WIDTH{1'b0}};
    bus.rw_addr_valid_o  = 1'b0;
    bus.rw_addr_o        = {ADDR_WIDTH{1'b0}};
    bus.rw_we_o          = 1'b0;
    bus.rw_len_o         = 8'd0;
    bus.rw_size_o        = 3'd0;
    bus.rw_burst_o       = 2'd0;
    bus.rw_if_o          = 1'b0;
    bus.w_data_valid_o   = 1'b0;
    bus.w_data_o         = {DATA_WIDTH{1'b0}};
    bus.r_data_ready_o   = 1'b0;
    case (rst ? IDLE : state_q)
      ADDR: begin
        if (owner_q == OWNER_LSU) begin
          bus.rw_addr_valid_o = bus.ls_req_valid_i;
          bus.rw_addr_o       = bus.ls_addr_i;
          bus.rw_we_o         = bus.ls_we_i;
          bus.rw_len_o        = bus.ls_len_i;
          bus.rw_size_o       = bus.ls_size_i;
          bus.rw_burst_o      = bus.ls_burst_i;
          bus.ls_req_ready_o  = bus.rw_addr_ready_i;
        end else begin
          bus.rw_addr_valid_o = bus.if_req_valid_i;
          bus.rw_addr_o       = bus.if_addr_i;
          bus.rw_len_o        = bus.if_len_i;
          bus.rw_size_o       = bus.if_size_i;
          bus.rw_burst_o      = bus.if_burst_i;
          bus.rw_if_o         = 1'b1;
          bus.if_req_ready_o  = bus.rw_addr_ready_i;
        end
      end
      RDATA: begin
        if (owner_q == OWNER_LSU) begin
          bus.ls_rdata_valid_o = bus.r_data_valid_i;
          bus.ls_rdata_o       = bus.r_data_i;
          bus.r_data_ready_o   = bus.ls_rdata_ready_i;
        end else begin
          bus.if_rdata_valid_o = bus.r_data_valid_i;
          bus.if_rdata_o       = bus.r_data_i;
          bus.r_data_ready_o   = bus.if_rdata_ready_i;
        end
      end
      WDATA: begin
        bus.w_data_valid_o   = bus.ls_wdata_valid_i;
        bus.w_data_o         = bus.ls_wdata_i;
        bus.ls_wdata_ready_o = bus.w_data_ready_i;
      end
      default: begin
        bus.rw_if_o = 1'b0;
      end
    endcase
  end

  // Ownership FSM; the last beat is detected by comparing before the increment so len 255 works.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IFU;
      last_grant_q <= OWNER_IFU;
      len_q        <= 8'd0;
      beat_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req_valid_i | bus.ls_req_valid_i) begin
            owner_q      <= grant_ls_s;
            last_grant_q <= grant_ls_s;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (addr_hs_s) begin
            len_q      <= bus.rw_len_o;
            beat_cnt_q <= 8'd0;
            state_q    <= bus.rw_we_o ? WDATA : RDATA;
          end
        end
        RDATA, WDATA: begin
          if (data_hs_s) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_cnt_q == len_q) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
